if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the IF/ID boundary of the 5-stage MIPS pipeline.
//  Owns the PC and runs a req/ack handshake to a variable-latency instruction memory.
//  Absorbs hazard stalls with a 1-entry skid buffer.
//  Applies taken-branch redirects from EX/MEM, squashing wrong-path fetches.
//  Outputs a registered IF/ID bundle (valid, instruction, PC+4) to decode.
// PARAMETERS
//  ADDR_W    32   PC / memory address width
//  DATA_W    32   instruction width
//  RESET_PC  0    PC value loaded at reset
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       reset, asynchronous, active-low
//  start_i        in   1       run enable, sampled only in IDLE
//  imem_req_o     out  1       fetch request
//  imem_addr_o    out  ADDR_W  fetch address; held stable while req=1 and no ack
//  imem_ack_i     in   1       data valid, completes the current request
//  imem_data_i    in   DATA_W  instruction returned with ack
//  stall_i        in   1       hazard unit: hold IF/ID and stop issuing
//  redirect_i     in   1       taken branch (EX/MEM Branch & Zero)
//  redirect_pc_i  in   ADDR_W  branch target; bits [1:0] ignored (forced 00)
//  ifid_valid_o   out  1       IF/ID holds a real instruction
//  ifid_inst_o    out  DATA_W  instruction; 32'h0 (NOP) when invalid
//  ifid_pc4_o     out  ADDR_W  PC+4 of that instruction
//  pc_o           out  ADDR_W  next PC to fetch
// BEHAVIOUR
//  Reset (async, immediate)
//   - state=IDLE, pc=RESET_PC, req=0.
//   - ifid_valid/inst/pc4 = 0, skid empty.
//  Reset mid-transaction drops req at once; any later ack is ignored.
//  Request register
//   - req_addr is latched when a request is issued.
//   - imem_addr_o = req_addr.
//   - imem_req_o = 1 only in FETCH and DISCARD.
//  IDLE
//   - On start_i=1, go to FETCH next cycle.
//   - Once running, the stage stays running until reset.
//  FETCH
//   - ack & !stall: IF/ID <= {1, data, req_addr+4}; pc += 4; next request issued
//     next cycle. Peak rate with a same-cycle ack is 1 instruction/cycle.
//   - ack & stall: IF/ID held; data and pc4 go to skid; pc += 4; go to HOLD.
//   - !ack: hold req_addr and wait.
//   - While stall_i=1 and no request is outstanding, no new request is issued.
//  HOLD
//   - req=0.
//   - When stall falls: IF/ID <= skid (valid=1), skid emptied, go to FETCH.
//  DISCARD
//   - Keep req/addr until ack; drop the data; then go to FETCH at pc.
//  Redirect (priority over stall and ack in every running state)
//   - pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}.
//   - ifid_valid <= 0 and inst <= 0; skid cleared.
//   - FETCH with no ack -> DISCARD.
//   - FETCH with ack in the same cycle -> data dropped, stay in FETCH.
//   - HOLD -> FETCH.
//   - Redirect in DISCARD updates pc only.
//  Stall with an empty pipe leaves IF/ID unchanged.
//   Valid=0 is held as a bubble, never replayed.
//  Arithmetic: PC+4 wraps modulo 2^ADDR_W.
//  Latency: ack at edge N -> ifid_valid_o=1 after edge N (zero-wait memory).
// STRUCTURE
//  cpu_pkg:
//   - fetch_state_t {IDLE, FETCH, HOLD, DISCARD}
//   - NOP_INST = 32'h0
//   - DEFAULT_RESET_PC
//  Sub-module if_skid_reg:
//   - 1-entry {valid, inst, pc4} holding register.
//   - load/clear inputs, async active-low reset.
//  Everything else (FSM, pc, req_addr, IF/ID register) is inline.
// TESTING
//  1. start_i=1, ack same cycle, data=addr^32'hA5A5_0000:
//     IF/ID shows pc4 4,8,12 with matching inst, valid every cycle.
//  2. Ack after 3 cycles: imem_addr_o stays 0x0 for 3 cycles.
//     Exactly one valid IF/ID beat per ack; inst never duplicated.
//  3. stall_i=1 for 2 cycles as ack for 0x8 arrives:
//     IF/ID holds the 0x4 instruction.
//     After stall falls, the 0x8 instruction (pc4=0xC) appears; no loss.
//  4. redirect_i to 0x100 while 0x10 is outstanding (ack 2 cycles later):
//     0x10 data never reaches IF/ID; next imem_addr_o=0x100; valid=0 meanwhile.
//  5. redirect_i, stall_i and ack all in one cycle, target 0x203:
//     next cycle valid=0, inst=0, pc_o=0x200.
//  6. RESET_PC=0xFFFF_FFFC, ack same cycle: ifid_pc4_o=0x0, next addr 0x0.
//     rst_i low between edges mid-FETCH: req and valid drop immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg: shared types and constants for the MIPS front end.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

`default_nettype wire

// File: rtl/if_skid_reg.sv
// ----------------------------------------------------------------------------
// if_skid_reg: one-entry {valid, inst, pc4} holding register for stalled fetches.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_skid_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc4_o
);

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc4_q;

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      inst_q  <= DATA_W'(NOP_INST);
      pc4_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      inst_q  <= DATA_W'(NOP_INST);
      pc4_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage: IF stage with imem req/ack, 1-entry skid and branch redirect.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              ifid_valid_o,
  output logic [DATA_W-1:0] ifid_inst_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [DATA_W-1:0] NOP     = DATA_W'(NOP_INST);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              pend_q, pend_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [DATA_W-1:0] ifid_inst_q, ifid_inst_d;
  logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;

  logic              req, ack;
  logic [ADDR_W-1:0] target, fetch_pc4;
  logic              skid_load, skid_clear, skid_valid;
  logic [DATA_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_pc4;

  // pend_q marks a request on the bus; req comes only from flops.
  assign req       = (state_q == DISCARD) || ((state_q == FETCH) && pend_q);
  assign ack       = req && imem_ack_i;
  assign target    = redirect_pc_i & ~ADDR_W'(3);
  assign fetch_pc4 = req_addr_q + PC_STEP;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    pend_d       = pend_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = FETCH;
          req_addr_d = pc_q;
          pend_d     = !stall_i;
        end
      end
      FETCH: begin
        if (redirect_i) begin
          pc_d         = target;
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP;
          skid_clear   = 1'b1;
          // An unanswered request must still be drained before refetching.
          if (pend_q && !imem_ack_i) begin
            state_d = DISCARD;
          end else begin
            req_addr_d = target;
            pend_d     = !stall_i;
          end
        end else if (ack) begin
          pc_d       = pc_q + PC_STEP;
          req_addr_d = pc_q + PC_STEP;
          if (stall_i) begin
            skid_load = 1'b1;
            pend_d    = 1'b0;
            state_d   = HOLD;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_inst_d  = imem_data_i;
            ifid_pc4_d   = fetch_pc4;
            pend_d       = 1'b1;
          end
        end else begin
          pend_d = pend_q || !stall_i;
          if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d         = target;
          req_addr_d   = target;
          ifid_valid_d = 1'b0;
          ifid_inst_d  = NOP;
          skid_clear   = 1'b1;
          pend_d       = !stall_i;
          state_d      = FETCH;
        end else if (!stall_i) begin
          ifid_valid_d = skid_valid;
          ifid_inst_d  = skid_inst;
          ifid_pc4_d   = skid_pc4;
          skid_clear   = 1'b1;
          req_addr_d   = pc_q;
          pend_d       = 1'b1;
          state_d      = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_i) pc_d = target;
        if (imem_ack_i) begin
          req_addr_d = pc_d;
          pend_d     = !stall_i;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      pend_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= NOP;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      pend_q       <= pend_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  if_skid_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .inst_i (imem_data_i),
    .pc4_i  (fetch_pc4),
    .valid_o(skid_valid),
    .inst_o (skid_inst),
    .pc4_o  (skid_pc4)
  );

  assign imem_req_o   = req;
  assign imem_addr_o  = req_addr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign pc_o         = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage: scoreboard bench for the IF stage against a latency-programmable memory.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, start = 1'b0, ack = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] data = '0, redirect_pc = '0;
  logic        req, valid;
  logic [31:0] addr, inst, pc4, pc;

  logic        rst_w_n = 1'b0, start_w = 1'b0, ack_w = 1'b0, stall_w = 1'b0, redirect_w = 1'b0;
  logic [31:0] data_w = '0, redirect_pc_w = '0;
  logic        req_w, valid_w;
  logic [31:0] addr_w, inst_w, pc4_w, pc_w;

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .ifid_valid_o(valid), .ifid_inst_o(inst), .ifid_pc4_o(pc4), .pc_o(pc)
  );

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst_w_n), .start_i(start_w),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w), .imem_data_i(data_w),
    .stall_i(stall_w), .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
    .ifid_valid_o(valid_w), .ifid_inst_o(inst_w), .ifid_pc4_o(pc4_w), .pc_o(pc_w)
  );

  int checks = 0, failures = 0;
  int lat = 0, wait_cnt = 0;
  logic        outstanding = 1'b0, drop_pend = 1'b0, hold_pend = 1'b0;
  logic        last_req = 1'b0, last_ack = 1'b0;
  logic [31:0] exp_addr = '0, held_addr = '0, last_addr = '0;
  logic [63:0] sb[$];

  // One clock of memory model + scoreboard; inputs are set by the caller beforehand.
  task automatic tick();
    logic [63:0] got, exp, dump;
    #1;
    last_req  = req;
    last_addr = addr;
    last_ack  = 1'b0;
    if (req) begin
      checks++;
      if (!outstanding && addr !== exp_addr) begin
        failures++;
        $display("FAIL addr_issue: addr=%h expected %h", addr, exp_addr);
      end else if (outstanding && addr !== held_addr) begin
        failures++;
        $display("FAIL addr_hold: addr=%h expected %h", addr, held_addr);
      end
      if (wait_cnt >= lat) begin
        ack      = 1'b1;
        data     = addr ^ K;
        last_ack = 1'b1;
      end
    end
    if (redirect) begin
      if (hold_pend) begin
        dump      = sb.pop_back();
        hold_pend = 1'b0;
      end
      drop_pend = last_req && !last_ack;
      exp_addr  = redirect_pc & ~32'h3;
    end else if (last_ack) begin
      if (drop_pend) begin
        drop_pend = 1'b0;
      end else begin
        sb.push_back({addr ^ K, addr + 32'd4});
        exp_addr = addr + 32'd4;
        if (stall) hold_pend = 1'b1;
      end
    end
    if (!stall) hold_pend = 1'b0;
    @(posedge clk);
    outstanding = last_req && !last_ack;
    held_addr   = last_addr;
    if (last_req && !last_ack) wait_cnt++;
    else wait_cnt = 0;
    #1;
    ack = 1'b0;
    if (valid && !stall) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: inst=%h pc4=%h expected no beat", inst, pc4);
      end else begin
        exp = sb.pop_front();
        got = {inst, pc4};
        if (got !== exp) begin
          failures++;
          $display("FAIL beat_data: {inst,pc4}=%h expected %h", got, exp);
        end
      end
    end else if (!valid) begin
      checks++;
      if (inst !== 32'h0) begin
        failures++;
        $display("FAIL bubble_nop: inst=%h expected 00000000", inst);
      end
    end
  endtask

  task automatic do_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: pending=%0d expected 0", sb.size());
    end
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; ack = 1'b0; redirect_pc = '0;
    sb.delete();
    outstanding = 1'b0; drop_pend = 1'b0; hold_pend = 1'b0; wait_cnt = 0; exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req !== 1'b0 || valid !== 1'b0 || inst !== 32'h0 || pc4 !== 32'h0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: req=%b valid=%b inst=%h pc4=%h pc=%h expected all zero",
               req, valid, inst, pc4, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (last_req !== 1'b0 || pc !== 32'h0) begin
        failures++;
        $display("FAIL idle_no_req: req=%b pc=%h expected req=0 pc=0", last_req, pc);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 0;
    run_start();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || pc4 !== 32'(4 * i) || inst !== (32'(4 * (i - 1)) ^ K)) begin
        failures++;
        $display("FAIL stream_beat%0d: valid=%b pc4=%h inst=%h expected 1 %h %h",
                 i, valid, pc4, inst, 32'(4 * i), 32'(4 * (i - 1)) ^ K);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    lat = 3;
    run_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (last_req !== 1'b1 || last_addr !== 32'h0 || last_ack || valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold%0d: req=%b addr=%h ack=%b valid=%b expected 1 0 0 0",
                 i, last_req, last_addr, last_ack, valid);
      end
    end
    tick();
    checks++;
    if (!last_ack || valid !== 1'b1 || pc4 !== 32'h4 || inst !== K) begin
      failures++;
      $display("FAIL slow_beat: ack=%b valid=%b pc4=%h inst=%h expected 1 1 4 %h",
               last_ack, valid, pc4, inst, K);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL no_duplicate: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 0;
    run_start();
    tick();
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if (!last_ack || last_addr !== 32'h8 || valid !== 1'b1 || pc4 !== 32'h8 || inst !== (32'h4 ^ K)) begin
      failures++;
      $display("FAIL stall_hold1: ack=%b addr=%h valid=%b pc4=%h inst=%h expected 1 8 1 8 %h",
               last_ack, last_addr, valid, pc4, inst, 32'h4 ^ K);
    end
    tick();
    checks++;
    if (last_req !== 1'b0 || valid !== 1'b1 || pc4 !== 32'h8) begin
      failures++;
      $display("FAIL stall_hold2: req=%b valid=%b pc4=%h expected 0 1 8", last_req, valid, pc4);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || pc4 !== 32'hC || inst !== (32'h8 ^ K)) begin
      failures++;
      $display("FAIL skid_release: valid=%b pc4=%h inst=%h expected 1 c %h", valid, pc4, inst, 32'h8 ^ K);
    end
    tick();
    checks++;
    if (last_addr !== 32'hC || valid !== 1'b1 || pc4 !== 32'h10) begin
      failures++;
      $display("FAIL after_skid: addr=%h valid=%b pc4=%h expected c 1 10", last_addr, valid, pc4);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 0;
    run_start();
    repeat (4) tick();
    lat = 2;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    checks++;
    if (last_addr !== 32'h10 || valid !== 1'b0 || pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect_kill: addr=%h valid=%b pc=%h expected 10 0 100", last_addr, valid, pc);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (last_req !== 1'b1 || valid !== 1'b0) begin
        failures++;
        $display("FAIL discard%0d: req=%b valid=%b expected 1 0", i, last_req, valid);
      end
    end
    lat = 0;
    tick();
    checks++;
    if (last_addr !== 32'h100 || valid !== 1'b1 || pc4 !== 32'h104 || inst !== (32'h100 ^ K)) begin
      failures++;
      $display("FAIL redirect_target: addr=%h valid=%b pc4=%h inst=%h expected 100 1 104 %h",
               last_addr, valid, pc4, inst, 32'h100 ^ K);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 0;
    run_start();
    tick();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick();
    stall = 1'b0;
    redirect = 1'b0;
    checks++;
    if (!last_ack || valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h200) begin
      failures++;
      $display("FAIL collide: ack=%b valid=%b inst=%h pc=%h expected 1 0 0 200", last_ack, valid, inst, pc);
    end
    tick();
    tick();
    checks++;
    if (last_addr !== 32'h200 || valid !== 1'b1 || pc4 !== 32'h204) begin
      failures++;
      $display("FAIL collide_refetch: addr=%h valid=%b pc4=%h expected 200 1 204", last_addr, valid, pc4);
    end
  endtask

  task automatic test_wrap_reset();
    rst_w_n = 1'b0; start_w = 1'b0; ack_w = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pc_w !== 32'hFFFF_FFFC || req_w !== 1'b0) begin
      failures++;
      $display("FAIL wrap_reset: pc=%h req=%b expected fffffffc 0", pc_w, req_w);
    end
    @(negedge clk);
    rst_w_n = 1'b1;
    start_w = 1'b1;
    @(posedge clk);
    #1;
    start_w = 1'b0;
    checks++;
    if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_req: req=%b addr=%h expected 1 fffffffc", req_w, addr_w);
    end
    ack_w  = 1'b1;
    data_w = 32'hFFFF_FFFC ^ K;
    @(posedge clk);
    #1;
    ack_w = 1'b0;
    checks++;
    if (valid_w !== 1'b1 || pc4_w !== 32'h0 || inst_w !== (32'hFFFF_FFFC ^ K)) begin
      failures++;
      $display("FAIL wrap_beat: valid=%b pc4=%h inst=%h expected 1 0 %h", valid_w, pc4_w, inst_w, 32'hFFFF_FFFC ^ K);
    end
    checks++;
    if (addr_w !== 32'h0 || pc_w !== 32'h0 || req_w !== 1'b1) begin
      failures++;
      $display("FAIL wrap_next: addr=%h pc=%h req=%b expected 0 0 1", addr_w, pc_w, req_w);
    end
    #2;
    rst_w_n = 1'b0;
    #1;
    checks++;
    if (req_w !== 1'b0 || valid_w !== 1'b0 || inst_w !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: req=%b valid=%b inst=%h expected 0 0 0", req_w, valid_w, inst_w);
    end
    ack_w  = 1'b1;
    data_w = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst_w_n = 1'b1;
    @(posedge clk);
    #1;
    ack_w = 1'b0;
    checks++;
    if (valid_w !== 1'b0 || req_w !== 1'b0) begin
      failures++;
      $display("FAIL late_ack: valid=%b req=%b expected 0 0", valid_w, req_w);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_final: pending=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule

`default_nettype wire
